md_pad_encoder_mp: RTL and testbench

Multi-port, fully synchronous Sega Mega Drive/Genesis controller encoder. Each of CHANNELS independent DB9 ports is driven from its own select line (pin 7) and its own 12-button bank. Each port can present as a 3-button or a 6-button pad, with a configurable idle timeout that resets the 6-button sequence. Sits between the button scanning/debounce logic and the DB9 output drivers.

---
 rtl/md_pad_encoder_mp.sv | 64 ++++++
 tb/tb_md_pad_encoder_mp.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/md_pad_encoder_mp.sv
// md_pad_encoder_mp: multi-port Mega Drive/Genesis 3/6-button pad encoder
// Ports:
//   clk, rst  - system clock, asynchronous active-high reset
//   sel       - per-port select (TH, DB9 pin 7) from console, bit n = port n
//   btn       - active-low buttons, slice n = {md,z,y,x,st,c,b,a,rg,lf,dw,up}
//   mode6     - per-port 1 = 6-button behaviour, 0 = 3-button
//   pins      - registered DB9 data, slice n = {p9,p6,p4,p3,p2,p1}
//   seq_cnt   - per-port select falling-edge count (debug visibility)
module md_pad_encoder_mp #(
  parameter int CHANNELS = 2,
  parameter int CLK_FREQ = 20000000,
  parameter int TIMEOUT_US = 1500,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CHANNELS-1:0]    sel,
  input  logic [12*CHANNELS-1:0] btn,
  input  logic [CHANNELS-1:0]    mode6,
  output logic [6*CHANNELS-1:0]  pins,
  output logic [3*CHANNELS-1:0]  seq_cnt
);
  localparam int TIMEOUT_CYC = (CLK_FREQ / 1000000) * TIMEOUT_US;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LOAD = TW'(TIMEOUT_CYC);
  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic                   s, s_d, edg, fall, timeout;
    logic [TW-1:0]          timer;
    logic [2:0]             cnt;
    logic [11:0]            b;
    logic [5:0]             dec, pins_q;
    assign s       = sync[SYNC_STAGES-1];
    assign edg     = s ^ s_d;
    assign fall    = s_d & ~s;
    // An edge always takes priority over an expiring timer
    assign timeout = (timer == '0) & ~edg;
    assign b       = btn[12*n +: 12];
    // Extended 6-button phases only exist for counts 3 and 4; beyond that the pad
    // falls back to the plain 3-button patterns
    always_comb begin
      dec = (mode6[n] && cnt == 3'd3) ? (s ? {2'b11, b[11], b[8], b[9], b[10]} : {b[7], b[4], 4'b0000}) :
            (mode6[n] && cnt == 3'd4 && !s) ? {b[7], b[4], 4'b1111} :
            s ? {b[6], b[5], b[3], b[2], b[1], b[0]} : {b[7], b[4], 2'b00, b[1], b[0]};
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync   <= '1;
        s_d    <= 1'b1;
        timer  <= T_LOAD;
        cnt    <= '0;
        pins_q <= '1;
      end else begin
        sync   <= {sync[SYNC_STAGES-2:0], sel[n]};
        s_d    <= s;
        timer  <= (edg || timer == '0) ? T_LOAD : timer - TW'(1);
        cnt    <= fall ? ((cnt == 3'd7) ? cnt : cnt + 3'd1) : (timeout ? 3'd0 : cnt);
        pins_q <= dec;
      end
    end
    assign pins[6*n +: 6]    = pins_q;
    assign seq_cnt[3*n +: 3] = cnt;
  end
endmodule

// File: tb/tb_md_pad_encoder_mp.sv
// tb_md_pad_encoder_mp: randomized + directed scoreboard bench for md_pad_encoder_mp
module tb_md_pad_encoder_mp;
  localparam int CH = 2;
  localparam int CLK_FREQ = 2000000;
  localparam int TIMEOUT_US = 50;
  localparam int SS = 2;
  localparam int T = (CLK_FREQ / 1000000) * TIMEOUT_US;
  localparam int HP = 20;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CH-1:0] sel = '1;
  logic [CH-1:0] mode6 = '1;
  logic [12*CH-1:0] btn = '1;
  logic [6*CH-1:0] pins;
  logic [3*CH-1:0] seq_cnt;
  int tests = 0;
  int fails = 0;
  typedef struct packed {
    logic [6*CH-1:0] p;
    logic [3*CH-1:0] c;
  } exp_t;
  exp_t sb[$];
  bit hist[CH][SS+1];
  int cnt_m[CH];
  int idle[CH];
  logic [5:0] lo6[4] = '{6'b110010, 6'b110010, 6'b110000, 6'b111111};
  logic [5:0] hi6[4] = '{6'b111110, 6'b111110, 6'b110011, 6'b111110};

  md_pad_encoder_mp #(.CHANNELS(CH), .CLK_FREQ(CLK_FREQ), .TIMEOUT_US(TIMEOUT_US), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .sel(sel), .btn(btn), .mode6(mode6), .pins(pins), .seq_cnt(seq_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] ref_pins(input logic s, input int c, input logic m6, input logic [11:0] k);
    logic up, dw, lf, rg, a, bb, cc, st, x, y, z, md;
    {md, z, y, x, st, cc, bb, a, rg, lf, dw, up} = k;
    if (s) return (m6 && c == 3) ? {1'b1, 1'b1, md, x, y, z} : {cc, bb, rg, lf, dw, up};
    if (m6 && c == 3) return {st, a, 4'b0000};
    if (m6 && c == 4) return {st, a, 4'b1111};
    return {st, a, 2'b00, dw, up};
  endfunction

  // Reference model: s is the select value sampled SS clocks ago; cnt counts falls
  // and is cleared once the select has been still for T+1 consecutive clocks.
  always @(posedge clk) begin
    exp_t e;
    logic s, sd;
    for (int n = 0; n < CH; n++) begin
      if (rst) begin
        for (int i = 0; i <= SS; i++) hist[n][i] = 1'b1;
        cnt_m[n] = 0;
        idle[n] = 0;
        e.p[6*n +: 6] = '1;
        e.c[3*n +: 3] = '0;
      end else begin
        s = hist[n][SS-1];
        sd = hist[n][SS];
        e.p[6*n +: 6] = ref_pins(s, cnt_m[n], mode6[n], btn[12*n +: 12]);
        if (s != sd) begin
          idle[n] = 0;
          if (sd && !s && cnt_m[n] < 7) cnt_m[n]++;
        end else begin
          idle[n]++;
          if (idle[n] == T + 1) begin
            idle[n] = 0;
            cnt_m[n] = 0;
          end
        end
        for (int i = SS; i > 0; i--) hist[n][i] = hist[n][i-1];
        hist[n][0] = sel[n];
        e.c[3*n +: 3] = 3'(cnt_m[n]);
      end
    end
    sb.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      tests++;
      if (pins !== e.p || seq_cnt !== e.c) begin
        fails++;
        $display("FAIL scoreboard t=%0t pins=%h seq_cnt=%h required pins=%h seq_cnt=%h", $time, pins, seq_cnt, e.p, e.c);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h required=%h", nm, got, exp);
    end
  endtask

  task automatic phase(input int p, input logic v, input int hp);
    sel[p] = v;
    repeat (hp) @(negedge clk);
  endtask

  task automatic run_seq(input bit six);
    for (int i = 0; i < 4; i++) begin
      phase(0, 1'b0, HP);
      chk("seq_low_pins", 32'(pins[5:0]), 32'(six ? lo6[i] : 6'b110010));
      chk("seq_low_cnt", 32'(seq_cnt[2:0]), 32'(i + 1));
      phase(0, 1'b1, HP);
      chk("seq_high_pins", 32'(pins[5:0]), 32'(six ? hi6[i] : 6'b111110));
    end
  endtask

  initial begin
    int hold[CH];
    repeat (3) @(negedge clk);
    chk("reset_pins", 32'(pins), 32'hfff);
    chk("reset_cnt", 32'(seq_cnt), 32'h0);
    rst = 1'b0;
    btn[11:0] = 12'h6FE;
    @(negedge clk);
    run_seq(1'b1);
    repeat (T - 30) @(negedge clk);
    chk("pre_timeout_cnt", 32'(seq_cnt[2:0]), 32'd4);
    repeat (40) @(negedge clk);
    chk("timeout_cnt", 32'(seq_cnt[2:0]), 32'd0);
    phase(0, 1'b0, HP);
    chk("post_timeout_low", 32'(pins[5:0]), 32'(6'b110010));
    phase(0, 1'b1, HP);
    repeat (T + 10) @(negedge clk);
    mode6[0] = 1'b0;
    run_seq(1'b0);
    mode6[0] = 1'b1;
    btn[23:12] = 12'hFBF;
    repeat (T + 10) @(negedge clk);
    chk("p1_idle_pins", 32'(pins[11:6]), 32'(6'b011111));
    sel[1] = 1'b0;
    repeat (SS) @(negedge clk);
    chk("p1_latency_before", 32'(pins[11:6]), 32'(6'b011111));
    @(negedge clk);
    chk("p1_latency_after", 32'(pins[11:6]), 32'(6'b110011));
    for (int i = 0; i < 4; i++) begin
      phase(1, 1'b1, 5);
      phase(1, 1'b0, 5);
    end
    chk("p0_isolated_pins", 32'(pins[5:0]), 32'(6'b111110));
    chk("p0_isolated_cnt", 32'(seq_cnt[2:0]), 32'd0);
    for (int i = 0; i < 9; i++) begin
      phase(1, 1'b1, 5);
      phase(1, 1'b0, 5);
    end
    chk("sat_cnt", 32'(seq_cnt[5:3]), 32'd7);
    chk("sat_low_pins", 32'(pins[11:6]), 32'(6'b110011));
    phase(1, 1'b1, 5);
    chk("sat_high_pins", 32'(pins[11:6]), 32'(6'b011111));
    chk("sat_high_cnt", 32'(seq_cnt[5:3]), 32'd7);
    sel[1] = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pins", 32'(pins), 32'hfff);
    chk("async_rst_cnt", 32'(seq_cnt), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < CH; n++) hold[n] = 1;
    repeat (4000) begin
      @(negedge clk);
      for (int n = 0; n < CH; n++) begin
        hold[n]--;
        if (hold[n] == 0) begin
          sel[n] = ~sel[n];
          hold[n] = ($urandom_range(9) == 0) ? int'($urandom_range(T + 30, T - 5)) : int'($urandom_range(30, 1));
        end
      end
      if ($urandom_range(7) == 0) btn = 24'($urandom);
      if ($urandom_range(200) == 0) mode6 = 2'($urandom);
    end
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
